// File: rtl/fire_pkg.sv
// Shared fire-layer types and constants.
// Used by the OFM serializer and its buffer.
package fire_pkg;

  localparam int WIDTH  = 16;
  localparam int CH     = 112;
  localparam int PIXELS = 64;
  localparam int CH_W   = $clog2(CH);
  localparam int PIX_W  = $clog2(PIXELS);

  typedef logic [WIDTH-1:0] act_t;
  typedef act_t [0:CH-1]    vec_t;
  typedef logic [CH_W-1:0]  ch_t;
  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } occ_t;

endpackage

// File: rtl/fire_ofm_serializer_if.sv
// Parallel-in / serial-out stream bundle.
// master = serializer side, slave = environment side.
interface fire_ofm_serializer_if;
  import fire_pkg::*;

  logic in_valid;
  vec_t in_vec;
  act_t out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  pix_t out_pix;

  modport master (
    input  in_valid,
    input  in_vec,
    input  out_ready,
    output out_data,
    output out_valid,
    output out_last,
    output out_pix
  );

  modport slave (
    output in_valid,
    output in_vec,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  out_last,
    input  out_pix
  );

endinterface

// File: rtl/fire_vec_buffer.sv
// Two CH-wide vector slots with a CH:1 read mux.
// Write slot picked by wp, read slot by rp.
module fire_vec_buffer
  import fire_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic wp,
  input  vec_t wr_vec,
  input  logic rp,
  input  ch_t  ch,
  output act_t rd_data
);

  vec_t mem0;
  vec_t mem1;
  vec_t rd_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem0 <= '0;
      mem1 <= '0;
    end else if (wr_en) begin
      if (wp) mem1 <= wr_vec;
      else    mem0 <= wr_vec;
    end
  end

  assign rd_vec  = rp ? mem1 : mem0;
  assign rd_data = rd_vec[ch];

endmodule

// File: rtl/fire_ofm_serializer.sv
// Double-buffered OFM vector serializer.
// Streams one channel per handshake, counts pixels.
module fire_ofm_serializer
  import fire_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  fire_ofm_serializer_if.master bus,
  output logic layer_done,
  output logic overflow
);

  occ_t occ;
  occ_t occ_nx;
  logic wp;
  logic rp;
  ch_t  ch;
  pix_t pix;
  act_t rd_data;

  logic valid_c;
  logic hs;
  logic fin;
  logic cap;
  logic drop;
  logic live_in;

  assign valid_c = (occ != EMPTY) & ~layer_done;
  assign hs      = valid_c & bus.out_ready;
  assign fin     = hs & (ch == ch_t'(CH-1));
  assign live_in = bus.in_valid & ~start & ~layer_done;
  // A full TWO still accepts when the final word frees a slot this edge.
  assign cap     = live_in & ((occ != TWO) | fin);
  assign drop    = live_in & (occ == TWO) & ~fin;

  fire_vec_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cap),
    .wp      (wp),
    .wr_vec  (bus.in_vec),
    .rp      (rp),
    .ch      (ch),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occ <= EMPTY;
    else      occ <= occ_nx;
  end

  always_comb begin
    occ_nx = occ;
    if (start) begin
      occ_nx = EMPTY;
    end else begin
      unique case (occ)
        EMPTY: if (cap) occ_nx = ONE;
        ONE: begin
          if (cap && !fin)      occ_nx = TWO;
          else if (fin && !cap) occ_nx = EMPTY;
        end
        TWO: if (fin && !cap) occ_nx = ONE;
        default: occ_nx = EMPTY;
      endcase
    end
  end

  always_comb begin
    bus.out_valid = valid_c;
    bus.out_data  = valid_c ? rd_data : '0;
    bus.out_last  = valid_c & (ch == ch_t'(CH-1));
    bus.out_pix   = pix;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp         <= 1'b0;
      rp         <= 1'b0;
      ch         <= '0;
      pix        <= '0;
      layer_done <= 1'b0;
      overflow   <= 1'b0;
    end else if (start) begin
      wp         <= 1'b0;
      rp         <= 1'b0;
      ch         <= '0;
      pix        <= '0;
      layer_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (cap)  wp       <= ~wp;
      if (drop) overflow <= 1'b1;
      if (fin) begin
        ch <= '0;
        rp <= ~rp;
        if (pix == pix_t'(PIXELS-1)) layer_done <= 1'b1;
        else                         pix <= pix + pix_t'(1);
      end else if (hs) begin
        ch <= ch + ch_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_fire_ofm_serializer.sv
// Directed bench for fire_ofm_serializer.
// Scoreboard of expected words checked on every handshake.
module tb_fire_ofm_serializer;
  import fire_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic layer_done;
  logic overflow;

  fire_ofm_serializer_if bus();

  fire_ofm_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus.master),
    .layer_done (layer_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    act_t data;
    logic last;
    pix_t pix;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_hs  = 0;
  logic rnd_rdy = 1'b0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic vec_t mk(int k);
    vec_t v;
    for (int i = 0; i < CH; i++)
      v[i] = act_t'((k << 8) + i + 1);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(int k, int p);
    vec_t v;
    v = mk(k);
    for (int i = 0; i < CH; i++)
      exp_q.push_back(exp_t'{v[i], (i == CH-1), pix_t'(p)});
  endtask

  task automatic send(int k, int p, bit cap);
    bus.in_valid = 1'b1;
    bus.in_vec   = mk(k);
    tick();
    bus.in_valid = 1'b0;
    if (cap) push(k, p);
  endtask

  task automatic send_free(int k, int p);
    int b;
    b = 0;
    while (exp_q.size() > CH && b < 5000) begin
      tick();
      b++;
    end
    chk("slot_wait", 32'(b < 5000), 1);
    send(k, p, 1'b1);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 20000) begin
      tick();
      b++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    exp_q.delete();
    tick();
    start = 1'b0;
  endtask

  task automatic monitor();
    logic pv;
    logic pr;
    logic ps;
    act_t pd;
    exp_t e;
    pv = 1'b0;
    pr = 1'b0;
    ps = 1'b0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (pv && !pr && !ps && rst) begin
        chk("hold_valid", 32'(bus.out_valid), 1);
        chk("hold_data", 32'(bus.out_data), 32'(pd));
      end
      if (exp_q.size() != 0)
        chk("no_gap", 32'(bus.out_valid), 1);
      if (bus.out_valid && bus.out_ready) begin
        n_hs++;
        chk("word_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("data", 32'(bus.out_data), 32'(e.data));
          chk("last", 32'(bus.out_last), 32'(e.last));
          chk("pix", 32'(bus.out_pix), 32'(e.pix));
        end
      end
      pv = bus.out_valid;
      pr = bus.out_ready;
      ps = start;
      pd = bus.out_data;
    end
  endtask

  initial begin
    int b;
    int h0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
    fork
      monitor();
    join_none

    #1 rst = 1'b0;
    #10;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_last", 32'(bus.out_last), 0);
    chk("rst_pix", 32'(bus.out_pix), 0);
    chk("rst_done", 32'(layer_done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    tick();
    rst = 1'b1;
    tick();

    // single vector, one-cycle latency
    bus.out_ready = 1'b1;
    do_start();
    send(0, 0, 1'b1);
    chk("lat_valid", 32'(bus.out_valid), 1);
    chk("lat_data", 32'(bus.out_data), 1);
    chk("lat_pix", 32'(bus.out_pix), 0);
    drain();
    chk("t1_empty", 32'(bus.out_valid), 0);

    // two vectors, zero bubble
    do_start();
    send(1, 0, 1'b1);
    tick();
    send(2, 1, 1'b1);
    drain();
    chk("t2_ovf", 32'(overflow), 0);

    // third vector while TWO is dropped
    do_start();
    send(3, 0, 1'b1);
    send(4, 1, 1'b1);
    repeat (10) tick();
    chk("t3_ovf_pre", 32'(overflow), 0);
    send(5, 2, 1'b0);
    chk("t3_ovf", 32'(overflow), 1);
    drain();
    chk("t3_ovf_sticky", 32'(overflow), 1);
    do_start();
    chk("t3_ovf_clr", 32'(overflow), 0);

    // third vector on the final-word edge is accepted
    send(6, 0, 1'b1);
    send(7, 1, 1'b1);
    b = 0;
    while (!(bus.out_last && bus.out_pix == 0) && b < 500) begin
      tick();
      b++;
    end
    chk("t4_wait", 32'(b < 500), 1);
    send(8, 2, 1'b1);
    chk("t4_ovf", 32'(overflow), 0);
    drain();
    chk("t4_ovf_end", 32'(overflow), 0);

    // start beats a same-cycle in_valid
    bus.in_valid = 1'b1;
    bus.in_vec   = mk(9);
    start        = 1'b1;
    exp_q.delete();
    tick();
    start        = 1'b0;
    bus.in_valid = 1'b0;
    chk("start_wins", 32'(bus.out_valid), 0);
    tick();
    chk("start_wins2", 32'(bus.out_valid), 0);

    // full layer with random backpressure
    do_start();
    rnd_rdy = 1'b1;
    h0 = n_hs;
    for (int k = 0; k < PIXELS; k++) send_free(k, k);
    chk("t5_done_pre", 32'(layer_done), 0);
    drain();
    chk("t5_done", 32'(layer_done), 1);
    chk("t5_words", 32'(n_hs - h0), 32'(PIXELS * CH));
    chk("t5_idle", 32'(bus.out_valid), 0);
    send(70, 0, 1'b0);
    tick();
    chk("t5_ignore", 32'(bus.out_valid), 0);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_done_hold", 32'(layer_done), 1);
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;

    // async reset at word 50 of pixel 3
    do_start();
    send(0, 0, 1'b1);
    send(1, 1, 1'b1);
    send_free(2, 2);
    send_free(3, 3);
    b = 0;
    while (!(bus.out_pix == 3 &&
             bus.out_data == act_t'((3 << 8) + 51)) &&
           b < 2000) begin
      tick();
      b++;
    end
    chk("t6_wait", 32'(b < 2000), 1);
    #1 rst = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_valid", 32'(bus.out_valid), 0);
    chk("t6_data", 32'(bus.out_data), 0);
    chk("t6_last", 32'(bus.out_last), 0);
    chk("t6_pix", 32'(bus.out_pix), 0);
    tick();
    rst = 1'b1;
    tick();
    do_start();
    send(11, 0, 1'b1);
    chk("t6_ch0", 32'(bus.out_data), 32'((11 << 8) + 1));
    chk("t6_pix0", 32'(bus.out_pix), 0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fire_ofm_serializer.md
# fire_ofm_serializer

Consumer-side counterpart of a fire squeeze layer. It captures the DSP_NO-wide parallel output-feature-map vector, one vector per output pixel, and streams it out one 16-bit channel value per cycle, in channel order, to the next serial-input layer (fire expand). It is double-buffered, so the squeeze layer never stalls while one vector is draining. It tracks pixel count and flags end-of-layer.

## Interface
- WIDTH, 16, activation word width
- CH, 112, channels per vector (equals the upstream DSP_NO/CHOUT)
- PIXELS, 64, vectors per layer (W_IN*H_IN, 8*8)
- clk  in  1  clock; all logic on its rising edge, no derived clocks
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; clears counters, buffers, done and overflow
- in_valid  in  1  single-cycle strobe, synchronous to clk, marking in_vec valid (replaces the upstream sampling clock)
- in_vec  in  WIDTH x [0:CH-1]  parallel post-ReLU channel vector
- out_data  out  WIDTH  current channel value
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data this cycle
- out_last  out  1  high with channel CH-1 of each vector
- out_pix  out  $clog2(PIXELS)  pixel index of the vector being streamed
- layer_done  out  1  all PIXELS*CH words transferred; sticky
- overflow  out  1  sticky error; a vector arrived while both buffers were full

## Operation
- Two vector buffers, B0 and B1, with 1-bit write pointer wp and read pointer rp. Occupancy FSM: EMPTY, ONE, TWO.
- Capture: in_valid in EMPTY or ONE writes in_vec to B[wp] and toggles wp. Occupancy goes +1.
- Drain: in ONE or TWO, out_valid=1 and out_data=B[rp][ch]. A handshake (out_valid & out_ready) increments ch.
  - Handshake at ch=CH-1: ch→0, rp toggles, out_pix increments, occupancy −1.
- Simultaneous capture and final-channel handshake: occupancy unchanged.
  - In TWO this capture is accepted (the slot frees the same edge). No overflow.
- in_valid in TWO without a final handshake: vector dropped, overflow←1, no other state change.
- out_data/out_valid hold stable while out_valid=1 and out_ready=0.
- layer_done←1 on the final handshake of pixel PIXELS-1.
  - After that, in_valid is ignored and out_valid stays 0 until start.
- start: occupancy→EMPTY, wp=rp=ch=out_pix=0, layer_done=0, overflow=0. Any in-flight vector is discarded.
  - start and in_valid in the same cycle: start wins; the vector is not captured.
- out_pix wraps never; the maximum value is PIXELS-1 before done.
- No arithmetic on data; values pass through bit-exact.

## Timing
- Reset values: out_data=0, out_valid=0, out_last=0, out_pix=0, layer_done=0, overflow=0. FSM is EMPTY with all pointers 0.
- Latency: in_valid at edge t (FSM EMPTY) → out_valid=1 with channel 0 after edge t, i.e. registered, 1 cycle.
- With out_ready held high, one vector takes exactly CH cycles.
- Back-to-back buffered vectors stream with zero bubble: channel 0 of the next vector follows channel CH-1 on the next cycle.
- out_last = out_valid & (ch==CH-1), all registered outputs.
- layer_done and overflow assert the cycle after the causing edge.
- Asynchronous reset mid-stream aborts immediately; outputs take their reset values without waiting for a clock edge.

## Structure
- Shared package fire_pkg holds:
  - WIDTH and the fire-layer CH/PIXELS constants.
  - typedef act_t (logic [WIDTH-1:0]).
  - typedef enum occ_t {EMPTY, ONE, TWO}.
- Sub-module fire_vec_buffer: the 2-entry CH-wide register storage plus the CH:1 read mux, ports wr_en/wp/wr_vec/rp/ch/rd_data.
- The top level keeps the FSM, counters and handshake.

## Test plan
- Reset, then start. Send one in_valid with in_vec[i]=i+1, out_ready=1 → 112 words 1..112, out_last only on word 112, out_pix=0, occupancy back to EMPTY.
- Two in_valid strobes 2 cycles apart, out_ready=1 → 224 consecutive valid words with no gap. out_pix goes 0→1 at word 113. overflow=0.
- Third in_valid while TWO, mid-drain → vector dropped, overflow=1 next cycle, the streamed data shows no trace of it.
- Third in_valid on exactly the last-channel handshake of the first vector → accepted, overflow=0, three vectors streamed in order.
- out_ready toggled randomly 50% → out_data stable whenever valid and not ready. Total 64*112=7168 words. layer_done=1 the cycle after the last; later in_valid ignored.
- Assert rst low at word 50 of pixel 3 → all outputs 0 immediately. After start, a fresh vector streams from channel 0, out_pix=0.
